// File: rtl/control_contador_if.sv
// control_contador_if: the button inputs and the counter-control outputs of
// the front-end stage, bundled into one connection.
//   rev_n, pause_n : raw active-low pushbuttons (driven by the board/master)
//   tick           : one-cycle count-enable pulse
//   rev            : debounced direction level (1 = count down)
//   control        : run/pause flag (0 = running, 1 = paused)
interface control_contador_if;
    logic rev_n;
    logic pause_n;
    logic tick;
    logic rev;
    logic control;

    modport master (
        output rev_n,
        output pause_n,
        input  tick,
        input  rev,
        input  control
    );

    modport slave (
        input  rev_n,
        input  pause_n,
        output tick,
        output rev,
        output control
    );
endinterface

// File: rtl/control_contador.sv
// control_contador: front end of the 4-bit up/down counter.
// Synchronizes and debounces the direction and pause buttons, turns pause
// presses into a run/pause toggle, and generates the count-enable timebase.
// Ports:
//   clk  : board clock, the only clock
//   rst  : synchronous active-high reset
//   bus  : control_contador_if.slave (rev_n, pause_n in; tick, rev, control out)
// Parameters:
//   DIV       : clk cycles per tick period (>= 2)
//   DB_CYCLES : consecutive stable cycles needed to accept a button change (>= 1)
module control_contador #(
    parameter int DIV       = 25_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    control_contador_if.slave   bus
);

    localparam int PW = $clog2(DIV);
    localparam int SW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] DB_LAST  = SW'(DB_CYCLES - 1);

    // Bit 0 is the direction button, bit 1 the pause button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    db_next;
    logic [SW-1:0] stable [2];
    logic [SW-1:0] stable_next [2];
    logic          db_pause_d;
    logic [PW-1:0] period;
    logic          tick_q;
    logic          rev_q;
    logic          control_q;

    assign raw = {bus.pause_n, bus.rev_n};

    // Next debounced level is computed up front so rev can update on the
    // same edge that db accepts a new level.
    always_comb begin
        db_next = db;
        for (int i = 0; i < 2; i++) begin
            stable_next[i] = '0;
            if (sync2[i] != db[i]) begin
                if (stable[i] == DB_LAST) begin
                    db_next[i] = sync2[i];
                end else begin
                    stable_next[i] = stable[i] + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '1;
            sync2      <= '1;
            db         <= '1;
            stable[0]  <= '0;
            stable[1]  <= '0;
            db_pause_d <= 1'b1;
            rev_q      <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            db         <= db_next;
            stable[0]  <= stable_next[0];
            stable[1]  <= stable_next[1];
            db_pause_d <= db[1];
            rev_q      <= ~db_next[0];
        end
    end

    // Toggle only on the press (1->0) of the debounced pause level; the
    // delayed copy makes the toggle land one edge after db falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            control_q <= 1'b0;
        end else if (db_pause_d && !db[1]) begin
            control_q <= ~control_q;
        end
    end

    // Timebase decisions use the pre-edge control value, so a pause landing
    // on the reload edge still lets that period's tick out.
    always_ff @(posedge clk) begin
        if (rst) begin
            period <= '0;
            tick_q <= 1'b0;
        end else if (control_q) begin
            tick_q <= 1'b0;
        end else if (period == PER_LAST) begin
            period <= '0;
            tick_q <= 1'b1;
        end else begin
            period <= period + PW'(1);
            tick_q <= 1'b0;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.rev     = rev_q;
    assign bus.control = control_q;

endmodule
